// File: rtl/run_monitor_pkg.sv
// Shared types and constants for the run monitor: FSM states, trace word indices, halt codes.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DUMP,
    ST_STEP,
    ST_DONE
  } state_e;

  // Word index is wide enough for NUM_REGS+1 with NUM_REGS up to 32.
  localparam int IDX_W = 6;

  localparam logic [IDX_W-1:0] WORD_STEP = 6'd0;
  localparam logic [IDX_W-1:0] WORD_PC   = 6'd1;
  localparam logic [IDX_W-1:0] WORD_REG0 = 6'd2;

  localparam logic HALT_STEPS = 1'b0;
  localparam logic HALT_STALL = 1'b1;

endpackage

// File: rtl/run_monitor_stall_det.sv
// Stall detector: latches the frame PC, counts consecutive frames with an unchanged PC.
// Latency: fire_o is registered, valid one cycle after the PC word is accepted; no backpressure of its own.
module run_monitor_stall_det
  import run_monitor_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int STALL_LIMIT = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cap_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            fire_o
);

  localparam int SC_W = $clog2(STALL_LIMIT + 1);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            have_prev_q, have_prev_d;
  logic [SC_W-1:0] stall_q, stall_d;

  always_comb begin
    pc_d        = pc_q;
    have_prev_d = have_prev_q;
    stall_d     = stall_q;
    if (cap_i) begin
      pc_d        = pc_i;
      have_prev_d = 1'b1;
      // The first frame has nothing to compare against, so it never counts as a repeat.
      if (have_prev_q && (pc_i == pc_q)) begin
        if (stall_q != SC_W'(STALL_LIMIT)) stall_d = stall_q + 1'b1;
      end else begin
        stall_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q        <= '0;
      have_prev_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      pc_q        <= pc_d;
      have_prev_q <= have_prev_d;
      stall_q     <= stall_d;
    end
  end

  assign fire_o = (stall_q == SC_W'(STALL_LIMIT));

endmodule

// File: rtl/run_monitor.sv
// run_monitor: freezes the CPU, streams a frame (step, PC, regs) combinationally per word index, then releases one step.
// tr_ready_i low holds the frame and keeps cpu_en_o low; RUN_MONITOR_STALL_HALT_EN adds the PC-stall halt.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PC_W        = 32,
  parameter int NUM_REGS    = 32,
  parameter int MAX_STEPS   = 30,
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic [4:0]        rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              cpu_en_o,
  output logic [DATA_W-1:0] tr_data_o,
  output logic              tr_valid_o,
  input  logic              tr_ready_i,
  output logic              tr_last_o,
  output logic              busy_o,
  output logic              halt_o,
  output logic              halt_reason_o,
  output logic [CNT_W-1:0]  step_cnt_o
);

  localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(NUM_REGS + 1);

  if (NUM_REGS < 1 || NUM_REGS > 32 || MAX_STEPS < 1 || PC_W > DATA_W || STALL_LIMIT < 1) begin : g_cfg_check
    $error("run_monitor: illegal parameter combination");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] w_q, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reason_q, reason_d;
  logic             stall_fire;

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    cnt_d      = cnt_q;
    reason_d   = reason_q;
    cpu_en_o   = 1'b0;
    tr_valid_o = 1'b0;
    tr_data_o  = '0;
    tr_last_o  = 1'b0;
    rd_addr_o  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_DUMP;
          w_d     = WORD_STEP;
        end
      end
      ST_DUMP: begin
        tr_valid_o = 1'b1;
        tr_last_o  = (w_q == WORD_LAST);
        if (w_q == WORD_STEP) begin
          tr_data_o = DATA_W'(cnt_q);
        end else if (w_q == WORD_PC) begin
          tr_data_o = DATA_W'(pc_i);
        end else begin
          rd_addr_o = 5'(w_q - WORD_REG0);
          tr_data_o = rd_data_i;
        end
        if (tr_ready_i) begin
          if (tr_last_o) begin
            cnt_d = cnt_q + 1'b1;
            // Step limit is checked first so it wins when both conditions land on one frame.
            if (cnt_d == CNT_W'(MAX_STEPS)) begin
              state_d  = ST_DONE;
              reason_d = HALT_STEPS;
            end else if (stall_fire) begin
              state_d  = ST_DONE;
              reason_d = HALT_STALL;
            end else begin
              state_d = ST_STEP;
            end
          end else begin
            w_d = w_q + 1'b1;
          end
        end
      end
      ST_STEP: begin
        cpu_en_o = 1'b1;
        state_d  = ST_DUMP;
        w_d      = WORD_STEP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      w_q      <= WORD_STEP;
      cnt_q    <= '0;
      reason_q <= HALT_STEPS;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      cnt_q    <= cnt_d;
      reason_q <= reason_d;
    end
  end

`ifdef RUN_MONITOR_STALL_HALT_EN
  logic pc_cap;
  assign pc_cap = (state_q == ST_DUMP) && (w_q == WORD_PC) && tr_ready_i;

  run_monitor_stall_det #(
    .PC_W        (PC_W),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall_det (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cap_i  (pc_cap),
    .pc_i   (pc_i),
    .fire_o (stall_fire)
  );
`else
  assign stall_fire = 1'b0;
`endif

  assign busy_o        = (state_q == ST_DUMP) || (state_q == ST_STEP);
  assign halt_o        = (state_q == ST_DONE);
  assign halt_reason_o = reason_q;
  assign step_cnt_o    = cnt_q;

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor with a scoreboard of expected trace words.
module tb_run_monitor;

  localparam int NR  = 8;
  localparam int MS  = 5;
  localparam int SL  = 2;
  localparam int WPF = NR + 2;
`ifdef RUN_MONITOR_STALL_HALT_EN
  localparam int   STALL_FRAMES = SL + 1;
  localparam logic STALL_REASON = 1'b1;
`else
  localparam int   STALL_FRAMES = MS;
  localparam logic STALL_REASON = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_i;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_i;
  logic        cpu_en_o;
  logic [31:0] tr_data_o;
  logic        tr_valid_o;
  logic        tr_ready_i;
  logic        tr_last_o;
  logic        busy_o;
  logic        halt_o;
  logic        halt_reason_o;
  logic [15:0] step_cnt_o;

  run_monitor #(
    .DATA_W      (32),
    .PC_W        (32),
    .NUM_REGS    (NR),
    .MAX_STEPS   (MS),
    .CNT_W       (16),
    .STALL_LIMIT (SL)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .pc_i          (pc_i),
    .rd_addr_o     (rd_addr_o),
    .rd_data_i     (rd_data_i),
    .cpu_en_o      (cpu_en_o),
    .tr_data_o     (tr_data_o),
    .tr_valid_o    (tr_valid_o),
    .tr_ready_i    (tr_ready_i),
    .tr_last_o     (tr_last_o),
    .busy_o        (busy_o),
    .halt_o        (halt_o),
    .halt_reason_o (halt_reason_o),
    .step_cnt_o    (step_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Register file model: reg k holds 100+k.
  assign rd_data_i = 32'd100 + 32'(rd_addr_o);

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb_dat[$];
  logic        sb_last[$];
  int          widx;
  int          en_pulses;
  bit          bp_mode;
  bit          pc_adv;
  bit          saw_en;
  int          n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    saw_en = cpu_en_o;
    if (cpu_en_o) begin
      en_pulses++;
      chk("cpu_en_during_frame", 32'(tr_valid_o), 32'd0);
    end
    if (tr_valid_o) begin
      if (sb_dat.size() == 0) begin
        chk("unexpected_word", 32'(tr_valid_o), 32'd0);
      end else begin
        chk("tr_data", tr_data_o, sb_dat[0]);
        chk("tr_last", 32'(tr_last_o), 32'(sb_last[0]));
        chk("rd_addr", 32'(rd_addr_o), (widx >= 2) ? 32'(widx - 2) : 32'd0);
        chk("busy_in_frame", 32'(busy_o), 32'd1);
        if (tr_ready_i) begin
          widx = sb_last[0] ? 0 : widx + 1;
          void'(sb_dat.pop_front());
          void'(sb_last.pop_front());
        end
      end
    end
  endtask

  // One clock: observe at the falling edge, drive just after the rising edge.
  task automatic step();
    @(negedge clk_i);
    monitor();
    @(posedge clk_i);
    #1;
    if (saw_en && pc_adv) pc_i = pc_i + 32'd4;
    tr_ready_i = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic push_run(input int nframes, input logic [31:0] pc0, input bit adv);
    logic [31:0] d;
    for (int f = 0; f < nframes; f++) begin
      for (int w = 0; w < WPF; w++) begin
        if (w == 0)      d = 32'(f);
        else if (w == 1) d = adv ? pc0 + 32'(4 * f) : pc0;
        else             d = 32'd100 + 32'(w - 2);
        sb_dat.push_back(d);
        sb_last.push_back(w == WPF - 1);
      end
    end
  endtask

  task automatic start_run(input int nframes, input logic [31:0] pc0, input bit adv, input bit bp);
    sb_dat.delete();
    sb_last.delete();
    widx      = 0;
    en_pulses = 0;
    pc_i      = pc0;
    pc_adv    = adv;
    bp_mode   = bp;
    push_run(nframes, pc0, adv);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("first_word_valid", 32'(tr_valid_o), 32'd1);
  endtask

  task automatic run_to_halt(output int cycles);
    cycles = 0;
    while (!halt_o && cycles < 4000) begin
      step();
      cycles++;
    end
    chk("halt_reached", 32'(halt_o), 32'd1);
    chk("sb_drained", 32'(sb_dat.size()), 32'd0);
    chk("busy_after_halt", 32'(busy_o), 32'd0);
  endtask

  task automatic reset_vals();
    chk("rst_cpu_en", 32'(cpu_en_o), 32'd0);
    chk("rst_tr_valid", 32'(tr_valid_o), 32'd0);
    chk("rst_tr_last", 32'(tr_last_o), 32'd0);
    chk("rst_tr_data", tr_data_o, 32'd0);
    chk("rst_rd_addr", 32'(rd_addr_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_halt", 32'(halt_o), 32'd0);
    chk("rst_reason", 32'(halt_reason_o), 32'd0);
    chk("rst_step_cnt", 32'(step_cnt_o), 32'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    reset_vals();
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i      = 1'b1;
    start_i    = 1'b0;
    tr_ready_i = 1'b1;
    pc_i       = '0;
    bp_mode    = 1'b0;
    pc_adv     = 1'b0;
    widx       = 0;
    en_pulses  = 0;
    #2;
    reset_vals();
    step();
    step();
    rst_i = 1'b0;
    step();

    // Full-rate run with an advancing PC.
    start_run(MS, 32'h100, 1'b1, 1'b0);
    run_to_halt(n);
    chk("runA_cycles", 32'(n), 32'(MS * WPF + MS - 1));
    chk("runA_reason", 32'(halt_reason_o), 32'd0);
    chk("runA_step_cnt", 32'(step_cnt_o), 32'(MS));
    chk("runA_cpu_en_pulses", 32'(en_pulses), 32'(MS - 1));

    // Start toggling in DONE must be ignored.
    for (int i = 0; i < 6; i++) begin
      start_i = 1'(i % 2 == 0);
      step();
      chk("done_no_valid", 32'(tr_valid_o), 32'd0);
      chk("done_halt_held", 32'(halt_o), 32'd1);
    end
    start_i = 1'b0;

    // Random backpressure: same word sequence, longer run.
    do_reset();
    start_run(MS, 32'h200, 1'b1, 1'b1);
    run_to_halt(n);
    chk("runB_reason", 32'(halt_reason_o), 32'd0);
    chk("runB_step_cnt", 32'(step_cnt_o), 32'(MS));
    chk("runB_cpu_en_pulses", 32'(en_pulses), 32'(MS - 1));

    // Reset in the middle of the first frame, at word 3.
    do_reset();
    start_run(MS, 32'h300, 1'b1, 1'b0);
    n = 0;
    while (widx != 3 && n < 100) begin
      step();
      n++;
    end
    chk("reached_word3", 32'(widx), 32'd3);
    do_reset();

    // Restart with PC frozen at 0x40 from the first frame.
    start_run(STALL_FRAMES, 32'h40, 1'b0, 1'b0);
    run_to_halt(n);
    chk("runD_reason", 32'(halt_reason_o), 32'(STALL_REASON));
    chk("runD_step_cnt", 32'(step_cnt_o), 32'(STALL_FRAMES));
    chk("runD_cpu_en_pulses", 32'(en_pulses), 32'(STALL_FRAMES - 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
